// File: rtl/shift_unit_sched_pkg.sv
// Shared definitions for the shift_unit_sched block.
//   - FSM state encoding
//   - shifter geometry (64-bit datapath, 5-bit shifter amount)
//   - prep_op(): builds the registered shifter operand from a granted request
package shift_unit_sched_pkg;

  localparam int SHIFT_W = 64;
  localparam int SAMT_W  = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  // Operand as it is captured on grant.
  typedef struct packed {
    logic               neg;  // result must be re-inverted after the shift
    logic [SHIFT_W-1:0] op;   // value fed to the zero-filling shifter
    logic [SAMT_W-1:0]  amt;  // residual amount 0..31
  } prep_t;

  // An arithmetic shift of a negative x equals ~(logical shift of ~x), so a
  // zero-filling shifter covers ASR when the operand is inverted on the way
  // in and the result inverted on the way out. Amounts of 32..63 are handled
  // by pre-aligning the upper half down, leaving a 0..31 residual shift.
  function automatic prep_t prep_op(input logic [SHIFT_W-1:0] data,
                                    input logic [SAMT_W:0]    samt,
                                    input logic               asr);
    prep_t p;
    p.neg = asr & data[SHIFT_W-1];
    p.op  = p.neg ? ~data : data;
    if (samt[SAMT_W]) begin
      p.op = {{(SHIFT_W/2){1'b0}}, p.op[SHIFT_W-1 -: SHIFT_W/2]};
    end
    p.amt = samt[SAMT_W-1:0];
    return p;
  endfunction

endpackage

// File: rtl/shift_unit_sched_if.sv
// Request/response bundle between the ALU issue logic, shift_unit_sched and
// the writeback mux.
//   req_valid/req_ready  per-requester handshake (NREQ bits each)
//   req_data             NREQ packed 64-bit operands, requester i at [64i +: 64]
//   req_samt             NREQ packed 6-bit amounts,   requester i at [6i +: 6]
//   req_asr              per-requester arithmetic-shift select
//   rsp_valid/rsp_ready  single response channel handshake
//   rsp_data, rsp_id     shifted result and owning requester index
// master: requesters + response consumer; slave: the scheduler.
interface shift_unit_sched_if
  import shift_unit_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);

  logic [NREQ-1:0]              req_valid;
  logic [NREQ-1:0]              req_ready;
  logic [NREQ*SHIFT_W-1:0]      req_data;
  logic [NREQ*(SAMT_W+1)-1:0]   req_samt;
  logic [NREQ-1:0]              req_asr;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [SHIFT_W-1:0]           rsp_data;
  logic [IDW-1:0]               rsp_id;

  modport master (
    output req_valid, req_data, req_samt, req_asr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_data, req_samt, req_asr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/shift_unit_sched_barrel_shift_right.sv
// barrel_shift_right: combinational logical right shifter, zeros shifted in.
//   din   W-bit operand
//   amt   AW-bit shift amount (0 .. 2**AW-1)
//   dout  din >> amt
// Built as AW log stages; stage s shifts by 2**s when amt[s] is set.
module barrel_shift_right #(
  parameter int W  = 64,
  parameter int AW = 5
) (
  input  logic [W-1:0]  din,
  input  logic [AW-1:0] amt,
  output logic [W-1:0]  dout
);

  logic [W-1:0] stage [AW+1];

  assign stage[0] = din;

  for (genvar s = 0; s < AW; s++) begin : g_stage
    assign stage[s+1] = amt[s] ? (stage[s] >> (1 << s)) : stage[s];
  end

  assign dout = stage[AW];

endmodule

// File: rtl/shift_unit_sched.sv
// shift_unit_sched: round-robin scheduler sharing one 64-bit / 5-bit-amount
// right barrel shifter among NREQ requesters. Adds a 0..63 amount range and
// arithmetic shifts around the unmodified shifter.
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  shift_unit_sched_if.slave (request handshakes in, tagged result out)
// Flow: grant (IDLE, or RESP on response handshake) -> SHIFT (1 cycle) ->
// RESP (hold result until consumer accepts). One result per 2 cycles max.
module shift_unit_sched
  import shift_unit_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  shift_unit_sched_if.slave bus
);

  state_t               state, state_nxt;
  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       id_reg;
  logic                 neg_reg;
  logic [SHIFT_W-1:0]   op_reg;
  logic [SAMT_W-1:0]    amt_reg;
  logic [SHIFT_W-1:0]   shifter_out;

  logic                 rsp_valid_reg;
  logic [SHIFT_W-1:0]   rsp_data_reg;
  logic [IDW-1:0]       rsp_id_reg;

  logic                 grant_any;
  logic [IDW-1:0]       grant_idx;
  logic                 grant_ok;
  logic                 do_grant;
  logic                 rsp_fire;
  logic [NREQ-1:0]      req_ready;

  logic [SHIFT_W-1:0]   sel_data;
  logic [SAMT_W:0]      sel_samt;
  logic                 sel_asr;
  prep_t                prep;

  assign rsp_fire = rsp_valid_reg && bus.rsp_ready;

  // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
  // NOTE: every always_comb output is given a default before any branch so
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_any && bus.req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        grant_any = 1'b1;
        grant_idx = IDW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  assign sel_data = bus.req_data[int'(grant_idx)*SHIFT_W +: SHIFT_W];
  assign sel_samt = bus.req_samt[int'(grant_idx)*(SAMT_W+1) +: (SAMT_W+1)];
  assign sel_asr  = bus.req_asr[grant_idx];
  assign prep     = prep_op(sel_data, sel_samt, sel_asr);

  // Next-state and grant qualification.
  always_comb begin
    state_nxt = state;
    grant_ok  = 1'b0;
    unique case (state)
      S_IDLE: begin
        grant_ok = 1'b1;
        if (grant_any) state_nxt = S_SHIFT;
      end
      S_SHIFT: state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_fire) begin
          grant_ok  = 1'b1;
          state_nxt = grant_any ? S_SHIFT : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Ready is combinational; gating with rst keeps it low while in reset even
  // though the idle state would otherwise accept a waiting request.
  assign do_grant = grant_ok && grant_any && !rst;

  always_comb begin
    req_ready = '0;
    if (do_grant) req_ready[grant_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the operand and result registers are reset too; rsp_data/rsp_id are
  // visible outputs with defined reset values, and the operand registers are
  // few enough that resetting them costs nothing worth avoiding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr        <= '0;
      id_reg        <= '0;
      neg_reg       <= 1'b0;
      op_reg        <= '0;
      amt_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_id_reg    <= '0;
    end else begin
      if (do_grant) begin
        id_reg  <= grant_idx;
        rr_ptr  <= IDW'((int'(grant_idx) + 1) % NREQ);
        neg_reg <= prep.neg;
        op_reg  <= prep.op;
        amt_reg <= prep.amt;
      end
      if (state == S_SHIFT) begin
        rsp_data_reg  <= neg_reg ? ~shifter_out : shifter_out;
        rsp_id_reg    <= id_reg;
        rsp_valid_reg <= 1'b1;
      end else if (state == S_RESP && rsp_fire) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  barrel_shift_right #(
    .W  (SHIFT_W),
    .AW (SAMT_W)
  ) u_shifter (
    .din  (op_reg),
    .amt  (amt_reg),
    .dout (shifter_out)
  );

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_id    = rsp_id_reg;

endmodule

// File: doc/shift_unit_sched.md
Name: shift_unit_sched

Overview:
- Round-robin scheduler that shares one 64-bit, 5-bit-amount right barrel shifter among NREQ requesters.
- Extends the shift range to 0..63 and adds an arithmetic-shift mode. Both are handled around the shifter, which stays unmodified.
- Each request is accepted with a valid/ready handshake and shifted in one cycle. The result returns on a single response channel tagged with the requester id.
- Sits between the ALU issue logic and the writeback mux.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, id width; must be at least clog2(NREQ).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept strobe.
- req_data  in  NREQ*64  operand; requester i uses bits [64i+63:64i].
- req_samt  in  NREQ*6  shift amount 0..63; requester i uses bits [6i+5:6i].
- req_asr  in  NREQ  1 = arithmetic right shift, 0 = logical right shift.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  64  shifted result.
- rsp_id  out  IDW  index of the requester that owns the result.

Behaviour:
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0, state=IDLE, rr_ptr=0 (requester 0 has highest priority).
- States: IDLE, SHIFT, RESP.
- Grant rule: the first asserted req_valid searched upward from rr_ptr, wrapping modulo NREQ.
- Grant is allowed in IDLE, or in RESP in the same cycle that rsp_valid && rsp_ready.
- req_ready[g] is combinational and is 1 only in the grant cycle. A requester must hold valid, data, samt and asr stable until it sees ready.
- On grant, the block registers:
  - id = g; rr_ptr = (g+1) mod NREQ.
  - neg = req_asr[g] && data[63].
  - op = neg ? ~data : data.
  - If samt[5]=1, op is pre-aligned: op = {32'b0, op[63:32]}.
  - amt = samt[4:0].
- Shifter: the sub-module input is op_reg, its amount is amt_reg, and zeros are shifted in.
- SHIFT (exactly one cycle):
  - rsp_data <= neg ? ~shifter_out : shifter_out.
  - rsp_id <= id; rsp_valid <= 1; state moves to RESP.
- RESP:
  - rsp_data and rsp_id hold while rsp_valid && !rsp_ready.
  - On handshake with a new grant: state moves to SHIFT and rsp_valid <= 0.
  - On handshake with no request pending: state moves to IDLE and rsp_valid <= 0.
- Latency and throughput: a grant at edge T gives rsp_valid=1 after edge T+2. Back-to-back throughput is one result per 2 cycles.
- Boundary cases:
  - samt=0 passes data through unchanged.
  - samt=63 logical gives 0 or 1.
  - samt=63 ASR of a negative operand gives all ones.
  - samt=32 gives data>>32.
- Simultaneous requests: only one grant per cycle. Losers keep valid asserted and req_ready low.
- A request arriving while the block is in SHIFT, or in RESP without a handshake, is not granted and waits.
- Reset mid-operation: asynchronous return to the reset values. An in-flight result is dropped with no partial response.
- Requesters with valid low are never granted, and rr_ptr is unchanged when no grant occurs.

Decomposition:
- Shared package holds:
  - state encoding constants S_IDLE=2'd0, S_SHIFT=2'd1, S_RESP=2'd2;
  - SHIFT_W=64 and SAMT_W=5.
- Sub-module: the existing barrel_shift_right, instantiated once and unmodified.
- The round-robin picker may live as a function or as inline logic. It is not a separate module.

Test Plan:
- Single request: req0 with data=64'hF000_0000_0000_0000, samt=4, asr=0 → req_ready[0] pulses once; 2 cycles later rsp_data=64'h0F00_0000_0000_0000, rsp_id=0.
- Extended range and ASR:
  - data=64'h8000_0000_0000_0000, samt=63, asr=1 → rsp_data=64'hFFFF_FFFF_FFFF_FFFF.
  - same data, samt=32, asr=0 → rsp_data=64'h0000_0000_8000_0000.
  - samt=0 → result equals data.
- Round-robin fairness: all 4 requesters held valid continuously → grant order 0,1,2,3,0.
  - With rsp_ready=1, consecutive rsp_valid pulses are 2 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles while req1 and req2 are valid → rsp_data and rsp_id stable and no req_ready pulses.
  - Releasing rsp_ready → req2 is granted in the same cycle as the handshake.
- Reset mid-operation: assert rst during SHIFT → outputs and state return to reset values immediately.
  - After release, a pending req3 is granted on the first eligible cycle, with priority starting from requester 0.
